// File: rtl/logic_writeback.sv
// logic_writeback: 2-entry result queue from the logic stage into the
// register-file write port, with Z/N/P flag update and a stall counter.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_valid       logic-stage result present
//   in_data[7:0]   result data
//   in_dest[2:0]   destination register
//   in_setflags    result updates flags on write-back
//   in_ready       queue can accept this cycle (registered count only)
//   wb_ready       register-file write port free
//   wb_en          write strobe, one cycle per entry
//   wb_addr[2:0]   write index
//   wb_data[7:0]   write data
//   flag_z/n/p     zero, negative, odd-parity flags
//   stall_clr      synchronous clear of stall_cnt
//   stall_cnt[7:0] saturating count of write-back stall cycles

module logic_writeback (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [2:0] in_dest,
  input  logic       in_setflags,
  output logic       in_ready,
  input  logic       wb_ready,
  output logic       wb_en,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_p,
  input  logic       stall_clr,
  output logic [7:0] stall_cnt
);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] dest;
    logic       setflags;
  } entry_t;

  entry_t     mem [2];
  logic [1:0] count;
  logic       wptr;
  logic       rptr;

  logic       push;
  logic       pop;
  logic       stall;
  entry_t     head;
  entry_t     inEntry;

  // Ready depends on registered count only, so no
  // combinational path from in_valid or wb_ready.
  assign in_ready = (count != 2'd2);

  assign push  = in_valid && in_ready;
  assign pop   = (count != 2'd0) && wb_ready;
  assign stall = (count != 2'd0) && !wb_ready;
  assign head  = mem[rptr];

  assign inEntry = '{
    data:     in_data,
    dest:     in_dest,
    setflags: in_setflags
  };

  // Queue storage; head is read before this edge's write,
  // so a freshly pushed entry cannot bypass to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wptr] <= inEntry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Write port: strobe only on pop, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_addr <= 3'd0;
      wb_data <= 8'd0;
    end else begin
      wb_en <= pop;
      if (pop) begin
        wb_addr <= head.dest;
        wb_data <= head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_p <= 1'b0;
    end else if (pop && head.setflags) begin
      flag_z <= (head.data == 8'd0);
      flag_n <= head.data[7];
      flag_p <= ^head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 8'd0;
    end else begin
      unique case (1'b1)
        stall_clr:
          stall_cnt <= 8'd0;
        stall && (stall_cnt != 8'hFF):
          stall_cnt <= stall_cnt + 8'd1;
        default:
          stall_cnt <= stall_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_writeback.sv
// tb_logic_writeback: directed self-checking bench for logic_writeback.
// Inputs change and outputs are sampled on the falling edge.

module tb_logic_writeback;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_setflags;
  logic       in_ready;
  logic       wb_ready;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       flag_z;
  logic       flag_n;
  logic       flag_p;
  logic       stall_clr;
  logic [7:0] stall_cnt;

  int errCnt;
  int chkCnt;
  int wbSeen;

  logic_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_dest     (in_dest),
    .in_setflags (in_setflags),
    .in_ready    (in_ready),
    .wb_ready    (wb_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_p      (flag_p),
    .stall_clr   (stall_clr),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(
    input logic       v,
    input logic [7:0] d,
    input logic [2:0] a,
    input logic       sf
  );
    in_valid    = v;
    in_data     = d;
    in_dest     = a;
    in_setflags = sf;
  endtask

  task automatic chkFlags(
    input string tag,
    input logic  z,
    input logic  n,
    input logic  p
  );
    chk(tag, {29'd0, flag_z, flag_n, flag_p}, {29'd0, z, n, p});
  endtask

  initial begin
    errCnt    = 0;
    chkCnt    = 0;
    rst_n     = 1'b0;
    wb_ready  = 1'b0;
    stall_clr = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0);

    #2;
    chk("rstReady", in_ready, 1);
    chk("rstWbEn", wb_en, 0);
    chk("rstAddr", wb_addr, 0);
    chk("rstData", wb_data, 0);
    chkFlags("rstFlags", 0, 0, 0);
    chk("rstStall", stall_cnt, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Single write of 0x00 to r3 with flags.
    wb_ready = 1'b1;
    drive(1'b1, 8'h00, 3'd3, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    chk("noBypass", wb_en, 0);
    tick();
    chk("w1En", wb_en, 1);
    chk("w1Addr", wb_addr, 3);
    chk("w1Data", wb_data, 8'h00);
    chkFlags("w1Flags", 1, 0, 0);
    tick();
    chk("w1Pulse", wb_en, 0);
    chk("w1AddrHold", wb_addr, 3);

    // Write of 0xF0 without setflags leaves flags alone.
    drive(1'b1, 8'hF0, 3'd5, 1'b0);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    tick();
    chk("w2En", wb_en, 1);
    chk("w2Addr", wb_addr, 5);
    chk("w2Data", wb_data, 8'hF0);
    chkFlags("w2FlagHold", 1, 0, 0);
    tick();

    // Fill with write port blocked.
    wb_ready = 1'b0;
    drive(1'b1, 8'h81, 3'd1, 1'b1);
    tick();
    drive(1'b1, 8'h7F, 3'd2, 1'b1);
    chk("fillReady1", in_ready, 1);
    tick();
    chk("fullReady", in_ready, 0);
    chk("stall1", stall_cnt, 1);
    drive(1'b1, 8'h55, 3'd6, 1'b1);
    tick();
    chk("stall2", stall_cnt, 2);
    chk("fullHold", in_ready, 0);
    chk("stallNoWb", wb_en, 0);
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    tick();
    chk("stall3", stall_cnt, 3);

    // Drain in order.
    wb_ready = 1'b1;
    tick();
    chk("d1En", wb_en, 1);
    chk("d1Data", wb_data, 8'h81);
    chk("d1Addr", wb_addr, 1);
    chk("d1Ready", in_ready, 1);
    chkFlags("d1Flags", 0, 1, 0);
    tick();
    chk("d2En", wb_en, 1);
    chk("d2Data", wb_data, 8'h7F);
    chk("d2Addr", wb_addr, 2);
    chkFlags("d2Flags", 0, 0, 1);
    chk("drainStall", stall_cnt, 3);
    tick();
    chk("ignoredIn", wb_en, 0);
    chk("emptyReady", in_ready, 1);

    // Saturate then clear.
    wb_ready = 1'b0;
    drive(1'b1, 8'h10, 3'd4, 1'b0);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    repeat (300) tick();
    chk("stallSat", stall_cnt, 8'hFF);
    stall_clr = 1'b1;
    tick();
    chk("stallClr", stall_cnt, 0);
    stall_clr = 1'b0;
    tick();
    chk("stallAfterClr", stall_cnt, 1);

    // Second entry queued, then reset mid-cycle.
    drive(1'b1, 8'h22, 3'd5, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    chk("preRstFull", in_ready, 0);
    chkFlags("preRstFlags", 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midRstReady", in_ready, 1);
    chk("midRstStall", stall_cnt, 0);
    chkFlags("midRstFlags", 0, 0, 0);
    chk("midRstWbEn", wb_en, 0);
    chk("midRstData", wb_data, 0);
    chk("midRstAddr", wb_addr, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    wbSeen   = 0;
    repeat (5) begin
      tick();
      if (wb_en) wbSeen++;
    end
    chk("noStaleWb", wbSeen, 0);

    // Normal operation after reset.
    drive(1'b1, 8'h01, 3'd7, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    tick();
    chk("postRstEn", wb_en, 1);
    chk("postRstData", wb_data, 8'h01);
    chk("postRstAddr", wb_addr, 7);
    chkFlags("postRstFlags", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
